// File: rtl/multicycle_control_unit.sv
// Control FSM for the shared multi-cycle RV32I datapath.
// Sequences IF/ID/EX/MEM/WB/PC4/HALT, drives datapath selects and strobes,
// stalls on the memory handshake and optionally times out a stuck handshake.
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_bcond,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       is_halted,
  output logic       mem_timeout
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_PC4  = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Counter wide enough to reach MEM_WAIT_MAX-1; one bit when the timeout is unused.
  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);
  localparam logic TIMEOUT_EN = (MEM_WAIT_MAX != 32'd0);

  state_t          state_r;
  state_t          next_state_s;
  logic [CW-1:0]   wait_cnt_r;
  logic            mem_timeout_r;
  logic            stall_s;
  logic            timeout_hit_s;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM: opcode_legal = 1'b1;
      default:                               opcode_legal = 1'b0;
    endcase
  endfunction

  assign stall_s       = ((state_r == S_IF) || (state_r == S_MEM)) && !mem_ready;
  assign timeout_hit_s = TIMEOUT_EN && stall_s && (wait_cnt_r == WAIT_LAST);
  assign is_halted     = (state_r == S_HALT);
  assign mem_timeout   = mem_timeout_r;

  // State sequencing, handshake wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IF;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
    end else if (timeout_hit_s) begin
      state_r       <= S_HALT;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b1;
    end else begin
      state_r <= next_state_s;
      if (TIMEOUT_EN && stall_s) begin
        wait_cnt_r <= wait_cnt_r + CW'(1'b1);
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  // Per-state datapath controls and next-state selection (Mealy on mem_ready/alu_bcond).
  always_comb begin
    next_state_s = state_r;
    pc_write     = 1'b0;
    pc_source    = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    retire       = 1'b0;
    case (state_r)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          next_state_s = S_ID;
        end else begin
          next_state_s = S_IF;
        end
      end
      S_ID: begin
        // Speculative branch/jump target: ALUOut <= PC + imm.
        alu_src_b = 2'b10;
        if (!opcode_legal(opcode)) begin
          next_state_s = S_HALT;
        end else if ((opcode == OP_SYSTEM) && halt_req) begin
          next_state_s = S_HALT;
        end else begin
          next_state_s = S_EX;
        end
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a = 1'b1; alu_src_b = 2'b00; alu_op = 2'b10;
            next_state_s = S_WB;
          end
          OP_I: begin
            alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 2'b10;
            next_state_s = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 2'b00;
            next_state_s = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1; alu_src_b = 2'b00; alu_op = 2'b01;
            if (alu_bcond) begin
              pc_write = 1'b1; pc_source = 1'b1; retire = 1'b1;
              next_state_s = S_IF;
            end else begin
              next_state_s = S_PC4;
            end
          end
          OP_JAL: begin
            // Link (PC+4 from the ALU) and jump to ALUOut in one cycle.
            alu_src_a = 1'b0; alu_src_b = 2'b01; alu_op = 2'b00;
            reg_write = 1'b1; wb_sel = 2'b10;
            pc_write = 1'b1; pc_source = 1'b1; retire = 1'b1;
            next_state_s = S_IF;
          end
          OP_JALR: begin
            alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 2'b00;
            next_state_s = S_WB;
          end
          OP_SYSTEM: begin
            next_state_s = S_PC4;
          end
          default: begin
            next_state_s = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read     = 1'b1;
          next_state_s = mem_ready ? S_WB : S_MEM;
        end else begin
          mem_write    = 1'b1;
          next_state_s = mem_ready ? S_PC4 : S_MEM;
        end
      end
      S_WB: begin
        alu_src_a = 1'b0; alu_src_b = 2'b01; alu_op = 2'b00;
        reg_write = 1'b1; pc_write = 1'b1; retire = 1'b1;
        if (opcode == OP_LOAD) begin
          wb_sel = 2'b01; pc_source = 1'b0;
        end else if (opcode == OP_JALR) begin
          wb_sel = 2'b10; pc_source = 1'b1;
        end else begin
          wb_sel = 2'b00; pc_source = 1'b0;
        end
        next_state_s = S_IF;
      end
      S_PC4: begin
        alu_src_a = 1'b0; alu_src_b = 2'b01; alu_op = 2'b00;
        pc_write = 1'b1; pc_source = 1'b0; retire = 1'b1;
        next_state_s = S_IF;
      end
      S_HALT: begin
        next_state_s = S_HALT;
      end
      default: begin
        next_state_s = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each scenario queues per-cycle
// stimulus with the expected output vector, then replays and compares.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Output vector: pcw pcs iord mr mw irw rw wb[2] asa asb[2] aop[2] ret hlt to
  function automatic logic [16:0] ov(input logic pcw, input logic pcs, input logic io,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic rw, input logic [1:0] wb, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic ret, input logic hlt, input logic to);
    return {pcw, pcs, io, mr, mw, irw, rw, wb, asa, asb, aop, ret, hlt, to};
  endfunction

  localparam logic [16:0] IF_WAIT = ov(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0);
  localparam logic [16:0] IF_GO   = ov(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0);
  localparam logic [16:0] ID_V    = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,2'b00,1'b0,1'b0,1'b0);
  localparam logic [16:0] EX_R    = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0);
  localparam logic [16:0] EX_I    = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b10,1'b0,1'b0,1'b0);
  localparam logic [16:0] EX_LS   = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0);
  localparam logic [16:0] EX_BT   = ov(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b01,1'b1,1'b0,1'b0);
  localparam logic [16:0] EX_BN   = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0);
  localparam logic [16:0] EX_JAL  = ov(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b01,2'b00,1'b1,1'b0,1'b0);
  localparam logic [16:0] EX_EC   = 17'd0;
  localparam logic [16:0] MEM_LD  = ov(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0);
  localparam logic [16:0] MEM_ST  = ov(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0);
  localparam logic [16:0] WB_RI   = ov(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,2'b00,1'b1,1'b0,1'b0);
  localparam logic [16:0] WB_LD   = ov(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,2'b01,2'b00,1'b1,1'b0,1'b0);
  localparam logic [16:0] WB_JR   = ov(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b01,2'b00,1'b1,1'b0,1'b0);
  localparam logic [16:0] PC4_V   = ov(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b1,1'b0,1'b0);
  localparam logic [16:0] HALT_V  = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0);
  localparam logic [16:0] HALT_TO = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1,1'b1);

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       rdy;
    logic       bc;
    logic       hr;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, mem_ready, alu_bcond, halt_req;
  logic [6:0] opcode;
  logic       pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] wb_sel, alu_src_b, alu_op;
  logic       alu_src_a, retire, is_halted, mem_timeout;

  logic       reset_to, mem_ready_to;
  logic       pc_write_to, pc_source_to, iord_to, mem_read_to, mem_write_to, ir_write_to, reg_write_to;
  logic [1:0] wb_sel_to, alu_src_b_to, alu_op_to;
  logic       alu_src_a_to, retire_to, is_halted_to, mem_timeout_to;

  logic [16:0] obs, obs_to;
  assign obs = {pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_write, wb_sel,
                alu_src_a, alu_src_b, alu_op, retire, is_halted, mem_timeout};
  assign obs_to = {pc_write_to, pc_source_to, iord_to, mem_read_to, mem_write_to, ir_write_to,
                   reg_write_to, wb_sel_to, alu_src_a_to, alu_src_b_to, alu_op_to, retire_to,
                   is_halted_to, mem_timeout_to};

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .alu_bcond(alu_bcond), .halt_req(halt_req),
    .pc_write(pc_write), .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire),
    .is_halted(is_halted), .mem_timeout(mem_timeout)
  );

  multicycle_control_unit #(.MEM_WAIT_MAX(3)) dut_to (
    .clk(clk), .reset(reset_to), .opcode(opcode), .mem_ready(mem_ready_to),
    .alu_bcond(alu_bcond), .halt_req(halt_req),
    .pc_write(pc_write_to), .pc_source(pc_source_to), .iord(iord_to), .mem_read(mem_read_to),
    .mem_write(mem_write_to), .ir_write(ir_write_to), .reg_write(reg_write_to), .wb_sel(wb_sel_to),
    .alu_src_a(alu_src_a_to), .alu_src_b(alu_src_b_to), .alu_op(alu_op_to), .retire(retire_to),
    .is_halted(is_halted_to), .mem_timeout(mem_timeout_to)
  );

  int checks = 0;
  int errors = 0;
  stim_t       stim_q[$];
  logic [16:0] exp_q[$];

  task automatic push(input logic rst, input logic [6:0] op, input logic rdy,
                      input logic bc, input logic hr, input logic [16:0] e);
    stim_t s;
    s.rst = rst; s.op = op; s.rdy = rdy; s.bc = bc; s.hr = hr;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    reset = s.rst; opcode = s.op; mem_ready = s.rdy; alu_bcond = s.bc; halt_req = s.hr;
  endtask

  // Queue a complete non-halting instruction; stall = mem_ready-low cycles in MEM.
  task automatic push_instr(input logic [6:0] op, input logic bc, input int stall);
    push(1'b0, op, 1'b1, bc, 1'b0, IF_GO);
    push(1'b0, op, 1'b1, bc, 1'b0, ID_V);
    case (op)
      OP_R:      begin push(1'b0, op, 1'b1, bc, 1'b0, EX_R); push(1'b0, op, 1'b1, bc, 1'b0, WB_RI); end
      OP_I:      begin push(1'b0, op, 1'b1, bc, 1'b0, EX_I); push(1'b0, op, 1'b1, bc, 1'b0, WB_RI); end
      OP_LOAD: begin
        push(1'b0, op, 1'b1, bc, 1'b0, EX_LS);
        for (int i = 0; i < stall; i++) push(1'b0, op, 1'b0, bc, 1'b0, MEM_LD);
        push(1'b0, op, 1'b1, bc, 1'b0, MEM_LD);
        push(1'b0, op, 1'b1, bc, 1'b0, WB_LD);
      end
      OP_STORE: begin
        push(1'b0, op, 1'b1, bc, 1'b0, EX_LS);
        for (int i = 0; i < stall; i++) push(1'b0, op, 1'b0, bc, 1'b0, MEM_ST);
        push(1'b0, op, 1'b1, bc, 1'b0, MEM_ST);
        push(1'b0, op, 1'b1, bc, 1'b0, PC4_V);
      end
      OP_BRANCH: begin
        if (bc) push(1'b0, op, 1'b1, bc, 1'b0, EX_BT);
        else begin push(1'b0, op, 1'b1, bc, 1'b0, EX_BN); push(1'b0, op, 1'b1, bc, 1'b0, PC4_V); end
      end
      OP_JAL:    push(1'b0, op, 1'b1, bc, 1'b0, EX_JAL);
      OP_JALR:   begin push(1'b0, op, 1'b1, bc, 1'b0, EX_LS); push(1'b0, op, 1'b1, bc, 1'b0, WB_JR); end
      default:   begin push(1'b0, op, 1'b1, bc, 1'b0, EX_EC); push(1'b0, op, 1'b1, bc, 1'b0, PC4_V); end
    endcase
  endtask

  task automatic test_reset();
    stim_t s; logic [16:0] e; int n = 0;
    push(1'b1, OP_R, 1'b0, 1'b0, 1'b0, IF_WAIT);
    push(1'b0, OP_R, 1'b0, 1'b0, 1'b0, IF_WAIT);
    push(1'b0, OP_R, 1'b0, 1'b0, 1'b0, IF_WAIT);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset cyc%0d got=%b exp=%b", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_alu_ops();
    stim_t s; logic [16:0] e; int n = 0;
    push_instr(OP_R, 1'b0, 0);
    push_instr(OP_I, 1'b0, 0);
    push_instr(OP_R, 1'b0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL alu_ops cyc%0d got=%b exp=%b", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_mem();
    stim_t s; logic [16:0] e; int n = 0;
    push_instr(OP_LOAD, 1'b0, 2);
    push_instr(OP_STORE, 1'b0, 0);
    push_instr(OP_STORE, 1'b0, 1);
    push_instr(OP_LOAD, 1'b0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem cyc%0d got=%b exp=%b", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_branch_jump();
    stim_t s; logic [16:0] e; int n = 0;
    push_instr(OP_BRANCH, 1'b1, 0);
    push_instr(OP_BRANCH, 1'b0, 0);
    push_instr(OP_JAL, 1'b0, 0);
    push_instr(OP_JALR, 1'b0, 0);
    push_instr(OP_BRANCH, 1'b1, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL branch_jump cyc%0d got=%b exp=%b", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_ecall_halt();
    stim_t s; logic [16:0] e; int n = 0;
    push_instr(OP_SYSTEM, 1'b0, 0);
    push(1'b0, OP_SYSTEM, 1'b1, 1'b0, 1'b1, IF_GO);
    push(1'b0, OP_SYSTEM, 1'b1, 1'b0, 1'b1, ID_V);
    for (int i = 0; i < 20; i++) push(1'b0, OP_SYSTEM, i[0], 1'b1, 1'b1, HALT_V);
    push(1'b1, OP_SYSTEM, 1'b0, 1'b0, 1'b0, HALT_V);
    push(1'b0, OP_SYSTEM, 1'b0, 1'b0, 1'b0, IF_WAIT);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL ecall_halt cyc%0d got=%b exp=%b", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_illegal();
    stim_t s; logic [16:0] e; int n = 0;
    push(1'b0, 7'b0000000, 1'b1, 1'b0, 1'b0, IF_GO);
    push(1'b0, 7'b0000000, 1'b1, 1'b0, 1'b0, ID_V);
    for (int i = 0; i < 3; i++) push(1'b0, OP_R, 1'b1, 1'b0, 1'b0, HALT_V);
    push(1'b1, OP_R, 1'b0, 1'b0, 1'b0, HALT_V);
    push(1'b0, OP_R, 1'b0, 1'b0, 1'b0, IF_WAIT);
    push_instr(OP_R, 1'b0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL illegal cyc%0d got=%b exp=%b", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset_in_mem();
    stim_t s; logic [16:0] e; int n = 0;
    push(1'b0, OP_STORE, 1'b1, 1'b0, 1'b0, IF_GO);
    push(1'b0, OP_STORE, 1'b1, 1'b0, 1'b0, ID_V);
    push(1'b0, OP_STORE, 1'b1, 1'b0, 1'b0, EX_LS);
    push(1'b0, OP_STORE, 1'b0, 1'b0, 1'b0, MEM_ST);
    push(1'b1, OP_STORE, 1'b0, 1'b0, 1'b0, MEM_ST);
    push(1'b0, OP_STORE, 1'b0, 1'b0, 1'b0, IF_WAIT);
    push_instr(OP_JAL, 1'b0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_in_mem cyc%0d got=%b exp=%b", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_timeout();
    stim_t s; logic [16:0] e; int n = 0;
    push(1'b1, OP_R, 1'b0, 1'b0, 1'b0, IF_WAIT);
    for (int i = 0; i < 3; i++) push(1'b0, OP_R, 1'b0, 1'b0, 1'b0, IF_WAIT);
    for (int i = 0; i < 4; i++) push(1'b0, OP_R, 1'b1, 1'b0, 1'b0, HALT_TO);
    push(1'b1, OP_R, 1'b1, 1'b0, 1'b0, HALT_TO);
    push(1'b0, OP_R, 1'b0, 1'b0, 1'b0, IF_WAIT);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset_to = s.rst; mem_ready_to = s.rdy; opcode = s.op; alu_bcond = s.bc; halt_req = s.hr;
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs_to !== e) begin errors++; $display("FAIL timeout cyc%0d got=%b exp=%b", n, obs_to, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; alu_bcond = 1'b0; halt_req = 1'b0; opcode = 7'd0;
    reset_to = 1'b1; mem_ready_to = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_alu_ops();
    test_mem();
    test_branch_jump();
    test_ecall_halt();
    test_illegal();
    test_reset_in_mem();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
